// File: rtl/fcmp_pipe.sv
// fcmp_pipe: two-stage pipelined single-precision floating-point compare unit.
// Operand pairs enter on a valid/ready interface with a user tag. Results leave
// two cycles later on a second valid/ready interface, and backpressure is
// fully supported. Stage 1 latches each operand's sign and magnitude together
// with its decoded class bits (nan, inf, zero). Stage 2 latches the final
// ordered-compare flags.
// Optional feature: define FCMP_STICKY_EN to add the sticky_clr input and the
// sticky_unordered / sticky_inf status outputs.
module fcmp_pipe #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_opa,
    input  logic [31:0]      in_opb,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_unordered,
    output logic             out_altb,
    output logic             out_blta,
    output logic             out_aeqb,
    output logic             out_inf,
    output logic             out_zero,
`ifdef FCMP_STICKY_EN
    input  logic             sticky_clr,
    output logic             sticky_unordered,
    output logic             sticky_inf,
`endif
    output logic             busy
);

    logic             r_s1Valid;
    logic             r_s1SignA, r_s1SignB;
    logic [30:0]      r_s1MagA, r_s1MagB;
    logic             r_s1NanA, r_s1NanB;
    logic             r_s1InfA, r_s1InfB;
    logic             r_s1ZeroA, r_s1ZeroB;
    logic [TAG_W-1:0] r_s1Tag;

    logic             r_s2Valid;
    logic [TAG_W-1:0] r_s2Tag;
    logic             r_s2Unordered, r_s2Altb, r_s2Blta, r_s2Aeqb, r_s2Inf, r_s2Zero;

    logic             w_adv2;
    logic             w_adv1;
    logic             w_unordered, w_altb, w_blta, w_aeqb, w_inf, w_zero;

    // Stage 2 advances whenever it is empty or its result is being consumed.
    // Stage 1 follows stage 2, and it still accepts input while it is empty.
    always_comb begin
        w_adv2   = !r_s2Valid || out_ready;
        w_adv1   = w_adv2;
        in_ready = rst_n && (!r_s1Valid || w_adv1);
    end

    // Stage 1: capture the operands split into sign and magnitude, plus their class bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1Valid <= 1'b0;
            r_s1SignA <= 1'b0;
            r_s1SignB <= 1'b0;
            r_s1MagA  <= '0;
            r_s1MagB  <= '0;
            r_s1NanA  <= 1'b0;
            r_s1NanB  <= 1'b0;
            r_s1InfA  <= 1'b0;
            r_s1InfB  <= 1'b0;
            r_s1ZeroA <= 1'b0;
            r_s1ZeroB <= 1'b0;
            r_s1Tag   <= '0;
        end else if (in_ready) begin
            r_s1Valid <= in_valid;
            r_s1SignA <= in_opa[31];
            r_s1SignB <= in_opb[31];
            r_s1MagA  <= in_opa[30:0];
            r_s1MagB  <= in_opb[30:0];
            r_s1NanA  <= (in_opa[30:23] == 8'hff) && (in_opa[22:0] != 23'd0);
            r_s1NanB  <= (in_opb[30:23] == 8'hff) && (in_opb[22:0] != 23'd0);
            r_s1InfA  <= (in_opa[30:23] == 8'hff) && (in_opa[22:0] == 23'd0);
            r_s1InfB  <= (in_opb[30:23] == 8'hff) && (in_opb[22:0] == 23'd0);
            r_s1ZeroA <= (in_opa[30:0] == 31'd0);
            r_s1ZeroB <= (in_opb[30:0] == 31'd0);
            r_s1Tag   <= in_tag;
        end
    end

    // Ordered-compare decision from the stage 1 class bits. Denormals are
    // compared as raw magnitudes. When both operands are negative, the
    // magnitude order is reversed.
    always_comb begin
        w_unordered = r_s1NanA || r_s1NanB;
        w_inf       = r_s1InfA || r_s1InfB;
        w_zero      = r_s1ZeroA;
        w_altb      = 1'b0;
        w_blta      = 1'b0;
        w_aeqb      = 1'b0;
        if (!w_unordered) begin
            if (r_s1ZeroA && r_s1ZeroB) begin
                w_aeqb = 1'b1;
            end else if (r_s1SignA != r_s1SignB) begin
                w_altb = r_s1SignA;
                w_blta = r_s1SignB;
            end else if (r_s1MagA == r_s1MagB) begin
                w_aeqb = 1'b1;
            end else if (r_s1SignA) begin
                w_altb = (r_s1MagA > r_s1MagB);
                w_blta = (r_s1MagA < r_s1MagB);
            end else begin
                w_altb = (r_s1MagA < r_s1MagB);
                w_blta = (r_s1MagA > r_s1MagB);
            end
        end
    end

    // Stage 2: register the flags. Each flag is gated by the valid bit, so the
    // outputs are 0 whenever no result is present.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2Valid     <= 1'b0;
            r_s2Tag       <= '0;
            r_s2Unordered <= 1'b0;
            r_s2Altb      <= 1'b0;
            r_s2Blta      <= 1'b0;
            r_s2Aeqb      <= 1'b0;
            r_s2Inf       <= 1'b0;
            r_s2Zero      <= 1'b0;
        end else if (w_adv2) begin
            r_s2Valid     <= r_s1Valid;
            r_s2Tag       <= r_s1Valid ? r_s1Tag : '0;
            r_s2Unordered <= r_s1Valid && w_unordered;
            r_s2Altb      <= r_s1Valid && w_altb;
            r_s2Blta      <= r_s1Valid && w_blta;
            r_s2Aeqb      <= r_s1Valid && w_aeqb;
            r_s2Inf       <= r_s1Valid && w_inf;
            r_s2Zero      <= r_s1Valid && w_zero;
        end
    end

    // Drive the retire interface from stage 2. The unit is busy while either stage holds an entry.
    always_comb begin
        out_valid     = r_s2Valid;
        out_tag       = r_s2Tag;
        out_unordered = r_s2Unordered;
        out_altb      = r_s2Altb;
        out_blta      = r_s2Blta;
        out_aeqb      = r_s2Aeqb;
        out_inf       = r_s2Inf;
        out_zero      = r_s2Zero;
        busy          = r_s1Valid || r_s2Valid;
    end

`ifdef FCMP_STICKY_EN
    logic r_stickyUnordered;
    logic r_stickyInf;
    logic w_retire;

    // A result retires when the consumer takes it.
    always_comb begin
        w_retire = r_s2Valid && out_ready;
    end

    // Sticky status bits. A set in the same cycle as a clear takes priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stickyUnordered <= 1'b0;
            r_stickyInf       <= 1'b0;
        end else begin
            if (w_retire && r_s2Unordered) begin
                r_stickyUnordered <= 1'b1;
            end else if (sticky_clr) begin
                r_stickyUnordered <= 1'b0;
            end
            if (w_retire && r_s2Inf) begin
                r_stickyInf <= 1'b1;
            end else if (sticky_clr) begin
                r_stickyInf <= 1'b0;
            end
        end
    end

    // Expose the sticky bits.
    always_comb begin
        sticky_unordered = r_stickyUnordered;
        sticky_inf       = r_stickyInf;
    end
`endif

endmodule
